// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

   localparam int DW         = 64;
   localparam int AW         = 5;
   localparam int ZR_IDX     = 31;
   localparam int STARVE_MAX = 4;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_req_t;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Valid/ready writeback handshake for requesters A (ALU) and B (load).
interface regfile_wr_arbiter_if;
   import regfile_pkg::*;

   logic          a_valid;
   logic          a_ready;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_data;
   logic          b_valid;
   logic          b_ready;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_data;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin or fixed priority (A over B) with B starvation escape.
module rr_arb2
   import regfile_pkg::*;
#(
   parameter int STARVE_LIM = STARVE_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       prio_mode,
   input  logic [1:0] req,
   input  grant_e     last_grant,
   output logic [1:0] grant
);

   localparam int CW = $clog2(STARVE_LIM + 1);

   logic [CW-1:0] starve_cnt;
   logic          contested;

   assign contested = &req;

   // NOTE: grant gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      grant = 2'b00;
      if (reset) begin
         if (contested) begin
            if (prio_mode)
               grant = (starve_cnt == CW'(STARVE_LIM)) ? 2'b10 : 2'b01;
            else
               grant = (last_grant == GRANT_A) ? 2'b10 : 2'b01;
         end else begin
            grant = req;
         end
      end
   end

   // Counts contested cycles B loses in either mode, so a mode switch keeps the history.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset)
         starve_cnt <= '0;
      else if (grant[1])
         starve_cnt <= '0;
      else if (contested && starve_cnt != CW'(STARVE_LIM))
         starve_cnt <= starve_cnt + 1'b1;
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback.
// Optional read bypass of the in-progress write is enabled with RF_WB_BYPASS_EN.
module regfile_wr_arbiter
   import regfile_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 prio_mode,
   regfile_wr_arbiter_if.slave  wb,
   output logic                 we3,
   output logic [AW-1:0]        wa3,
   output logic [DW-1:0]        wd3,
   output logic                 last_grant,
   output logic [7:0]           drop_cnt
`ifdef RF_WB_BYPASS_EN
   ,
   input  logic [AW-1:0]        ra1,
   input  logic [AW-1:0]        ra2,
   input  logic [DW-1:0]        rf_rd1,
   input  logic [DW-1:0]        rf_rd2,
   output logic [DW-1:0]        rd1_byp,
   output logic [DW-1:0]        rd2_byp
`endif
);

   logic [1:0] grant;
   grant_e     last_q;
   wr_req_t    sel;
   logic       xfer;
   logic       zr_hit;

   rr_arb2 #(.STARVE_LIM(STARVE_MAX)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .prio_mode  (prio_mode),
      .req        ({wb.b_valid, wb.a_valid}),
      .last_grant (last_q),
      .grant      (grant)
   );

   assign wb.a_ready = grant[0];
   assign wb.b_ready = grant[1];
   assign xfer       = |grant;
   assign last_grant = last_q;

   always_comb begin
      sel.addr = wb.a_addr;
      sel.data = wb.a_data;
      if (grant[1]) begin
         sel.addr = wb.b_addr;
         sel.data = wb.b_data;
      end
   end

   assign zr_hit = xfer && (sel.addr == AW'(ZR_IDX));

   // Writes to the zero register finish the handshake but never raise we3.
   always_ff @(posedge clk) begin
      if (!reset) begin
         we3      <= 1'b0;
         wa3      <= '0;
         wd3      <= '0;
         last_q   <= GRANT_B;
         drop_cnt <= '0;
      end else begin
         we3 <= xfer && !zr_hit;
         if (xfer) begin
            wa3    <= sel.addr;
            wd3    <= sel.data;
            last_q <= grant[1] ? GRANT_B : GRANT_A;
         end
         if (zr_hit && drop_cnt != DROP_MAX)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

`ifdef RF_WB_BYPASS_EN
   assign rd1_byp = (we3 && ra1 == wa3) ? wd3 : rf_rd1;
   assign rd2_byp = (we3 && ra2 == wa3) ? wd3 : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter; bypass checks compile in with RF_WB_BYPASS_EN.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          prio_mode;
   logic          we3;
   logic [AW-1:0] wa3;
   logic [DW-1:0] wd3;
   logic          last_grant;
   logic [7:0]    drop_cnt;
`ifdef RF_WB_BYPASS_EN
   logic [AW-1:0] ra1 = '0;
   logic [AW-1:0] ra2 = '0;
   logic [DW-1:0] rf_rd1 = '0;
   logic [DW-1:0] rf_rd2 = '0;
   logic [DW-1:0] rd1_byp;
   logic [DW-1:0] rd2_byp;
`endif

   regfile_wr_arbiter_if bus ();

   regfile_wr_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .prio_mode  (prio_mode),
      .wb         (bus),
      .we3        (we3),
      .wa3        (wa3),
      .wd3        (wd3),
      .last_grant (last_grant),
      .drop_cnt   (drop_cnt)
`ifdef RF_WB_BYPASS_EN
      ,
      .ra1        (ra1),
      .ra2        (ra2),
      .rf_rd1     (rf_rd1),
      .rf_rd2     (rf_rd2),
      .rd1_byp    (rd1_byp),
      .rd2_byp    (rd2_byp)
`endif
   );

   always #5 clk = ~clk;

   int      total = 0;
   int      bad   = 0;
   wr_req_t sb[$];
   wr_req_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every register-file write must match the next expected entry.
   always @(negedge clk) begin
      if (we3) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_write: got write addr %0d, required no write", wa3);
         end else begin
            mon_e = sb.pop_front();
            check("sb_wa3", 64'(wa3), 64'(mon_e.addr));
            check("sb_wd3", wd3, mon_e.data);
         end
         check("zr_never_written", 64'(wa3 == AW'(ZR_IDX)), 64'(0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
   endtask

   function automatic wr_req_t mk(input int addr, input logic [63:0] data);
      wr_req_t r;
      r.addr = AW'(addr);
      r.data = data;
      return r;
   endfunction

   // Both sides valid for n cycles; pat[i]=1 means B is expected to win cycle i.
   task automatic contend(input int n, input logic [15:0] pat);
      int ai = 0;
      int bi = 0;
      for (int i = 0; i < n; i++) begin
         bus.a_valid = 1'b1;
         bus.a_addr  = AW'(1 + ai);
         bus.a_data  = 64'h100 + 64'(1 + ai);
         bus.b_valid = 1'b1;
         bus.b_addr  = AW'(11 + bi);
         bus.b_data  = 64'h200 + 64'(11 + bi);
         #2;
         check("contend_a_ready", 64'(bus.a_ready), 64'(!pat[i]));
         check("contend_b_ready", 64'(bus.b_ready), 64'(pat[i]));
         if (pat[i]) begin
            sb.push_back(mk(11 + bi, 64'h200 + 64'(11 + bi)));
            bi++;
         end else begin
            sb.push_back(mk(1 + ai, 64'h100 + 64'(1 + ai)));
            ai++;
         end
         tick();
      end
      idle();
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, required completion within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      prio_mode   = 1'b0;
      bus.a_valid = 1'b1;
      bus.a_addr  = AW'(2);
      bus.a_data  = 64'h22;
      bus.b_valid = 1'b0;
      bus.b_addr  = '0;
      bus.b_data  = '0;
      #1;
      check("rst_a_ready_gated", 64'(bus.a_ready), 64'(0));
      tick();
      tick();
      check("rst_we3", 64'(we3), 64'(0));
      check("rst_wa3", 64'(wa3), 64'(0));
      check("rst_wd3", wd3, 64'(0));
      check("rst_last_grant", 64'(last_grant), 64'(1));
      check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      idle();
      reset = 1'b1;
      tick();

      // Single requester A.
      bus.a_valid = 1'b1;
      bus.a_addr  = AW'(5);
      bus.a_data  = 64'hAA;
      #2;
      check("single_a_ready", 64'(bus.a_ready), 64'(1));
      check("single_b_ready", 64'(bus.b_ready), 64'(0));
      sb.push_back(mk(5, 64'hAA));
      tick();
      idle();
      check("single_we3_n1", 64'(we3), 64'(1));
      check("single_last_grant", 64'(last_grant), 64'(0));
      tick();
      check("single_we3_n2", 64'(we3), 64'(0));

      // Zero register writes from B: swallowed, counted, saturating.
      bus.b_valid = 1'b1;
      bus.b_addr  = AW'(ZR_IDX);
      bus.b_data  = 64'hFF;
      #2;
      check("zr_b_ready", 64'(bus.b_ready), 64'(1));
      tick();
      check("zr_we3", 64'(we3), 64'(0));
      check("zr_drop_1", 64'(drop_cnt), 64'(1));
      check("zr_last_grant", 64'(last_grant), 64'(1));
      check("zr_wa3_loaded", 64'(wa3), 64'(ZR_IDX));
      for (int i = 0; i < 299; i++) tick();
      check("zr_drop_sat", 64'(drop_cnt), 64'(255));
      idle();
      tick();

      // Round-robin contention after a B grant: A,B,A,B.
      prio_mode = 1'b0;
      contend(4, 16'b1010);

      // Fixed priority with starvation escape: A,A,A,A,B,A,A,A,A,B.
      prio_mode = 1'b1;
      contend(10, 16'b10_0001_0000);
      check("fixed_last_grant", 64'(last_grant), 64'(1));
      prio_mode = 1'b0;

      // Reset arriving while a write is in flight.
      bus.a_valid = 1'b1;
      bus.a_addr  = AW'(3);
      bus.a_data  = 64'h33;
      #2;
      check("mid_a_ready", 64'(bus.a_ready), 64'(1));
      sb.push_back(mk(3, 64'h33));
      tick();
      check("mid_we3_before_rst", 64'(we3), 64'(1));
      bus.a_addr = AW'(4);
      bus.a_data = 64'h44;
      reset      = 1'b0;
      #2;
      check("mid_no_handshake", 64'(bus.a_ready), 64'(0));
      tick();
      check("mid_rst_we3", 64'(we3), 64'(0));
      check("mid_rst_wa3", 64'(wa3), 64'(0));
      check("mid_rst_wd3", wd3, 64'(0));
      check("mid_rst_last_grant", 64'(last_grant), 64'(1));
      check("mid_rst_drop_cnt", 64'(drop_cnt), 64'(0));
      idle();
      reset = 1'b1;
      tick();

`ifdef RF_WB_BYPASS_EN
      bus.a_valid = 1'b1;
      bus.a_addr  = AW'(7);
      bus.a_data  = 64'h1234;
      #2;
      sb.push_back(mk(7, 64'h1234));
      tick();
      idle();
      ra1    = AW'(7);
      rf_rd1 = 64'h7;
      ra2    = AW'(8);
      rf_rd2 = 64'h8;
      #1;
      check("byp_rd1_hit", rd1_byp, 64'h1234);
      check("byp_rd2_miss", rd2_byp, 64'h8);
      tick();
      check("byp_rd1_no_write", rd1_byp, 64'h7);
`endif

      tick();
      tick();
      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
